// File: rtl/parallel_serial_tx.sv
// parallel_serial_tx
// Byte-to-serial transmitter for the comma-framed single-bit link.
// After reset it sends SYNC_COUNT comma bytes so the far end can find byte
// alignment. It then sends one byte every 8 clocks, MSB first, with no gaps.
// A byte is taken from the READY/VALID source at each slot boundary, and the
// comma byte fills any slot the source leaves empty.
module parallel_serial_tx #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         SYNC_COUNT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic       VALID_IN,
  output logic       READY,
  output logic       DATA_OUT,
  output logic       TX_SYNC
);

  localparam int SYNC_W = (SYNC_COUNT < 1) ? 1 : $clog2(SYNC_COUNT + 1);

  typedef enum logic {SYNC, DATA} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [7:0]        sh;
  logic [SYNC_W-1:0] sync_cnt;
  logic [7:0]        load_byte;
  logic              load;

  // A slot boundary (load edge) is the edge where the bit counter is zero.
  assign load = (cnt == 3'd0);

  // The source is offered a slot only in the data phase, and never while reset is held.
  assign READY = (state == DATA) && load && !RESET;

  // Select the byte for the next slot: source data when offered and valid, otherwise comma.
  always_comb begin
    load_byte = COM;
    if ((state == DATA) && VALID_IN) begin
      load_byte = DATA_IN;
    end
  end

  // Bit counter, shift register, sync preamble FSM and registered serial outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= SYNC;
      cnt      <= 3'd0;
      sync_cnt <= '0;
      sh       <= 8'd0;
      DATA_OUT <= 1'b0;
      TX_SYNC  <= 1'b1;
    end else begin
      cnt <= cnt + 3'd1;
      if (load) begin
        sh       <= load_byte;
        DATA_OUT <= load_byte[7];
        if (state == SYNC) begin
          sync_cnt <= sync_cnt + SYNC_W'(1);
          if (sync_cnt == SYNC_W'(SYNC_COUNT - 1)) begin
            state   <= DATA;
            TX_SYNC <= 1'b0;
          end
        end
      end else begin
        // Rotate rather than shift so that every bit of sh is read. The
        // wrapped bit is never sent, because the next load overwrites sh.
        sh       <= {sh[6:0], sh[7]};
        DATA_OUT <= sh[6];
      end
    end
  end

endmodule

// File: tb/tb_parallel_serial_tx.sv
// tb_parallel_serial_tx
// Drives two transmitters: A uses the default SYNC_COUNT of 2, and B uses
// SYNC_COUNT=1 and feeds a small comma-locking receiver. Both are compared
// on every cycle against an edge-index model of the link. Directed literal
// checks are placed at known edges.
module tb_parallel_serial_tx;

  localparam logic [7:0] COM = 8'hBC;

  logic       CLK;
  logic       RESET;
  logic [7:0] dataA, dataB;
  logic       validA, validB;
  logic       readyA, readyB;
  logic       doutA, doutB;
  logic       syncA, syncB;

  int total = 0;
  int bad   = 0;

  parallel_serial_tx #(.COM(COM), .SYNC_COUNT(2)) dutA (
    .CLK(CLK), .RESET(RESET), .DATA_IN(dataA), .VALID_IN(validA),
    .READY(readyA), .DATA_OUT(doutA), .TX_SYNC(syncA)
  );

  parallel_serial_tx #(.COM(COM), .SYNC_COUNT(1)) dutB (
    .CLK(CLK), .RESET(RESET), .DATA_IN(dataB), .VALID_IN(validB),
    .READY(readyB), .DATA_OUT(doutB), .TX_SYNC(syncB)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Sets the inputs for one cycle and then returns just after the next rising edge.
  task automatic applyStimulus(input logic r, input logic va, input logic [7:0] da,
                               input logic vb, input logic [7:0] db);
    RESET  = r;
    validA = va;
    dataA  = da;
    validB = vb;
    dataB  = db;
    @(posedge CLK);
    #2;
  endtask

  // Link model: counts edges since the last reset edge. Slot s = e/8 sends
  // a comma while s < SYNC_COUNT. Later slots send DATA_IN if VALID_IN was
  // high at the slot edge, and a comma otherwise. The bit sent is MSB first.
  int         syncCount [2] = '{2, 1};
  int         e         [2];
  logic [7:0] cur       [2];
  logic       expDo     [2];
  logic       expSync   [2];
  bit         live = 0;

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RESET) begin
        e[i]       = -1;
        cur[i]     = 8'd0;
        expDo[i]   = 1'b0;
        expSync[i] = 1'b1;
        live       = 1;
      end else if (live) begin
        e[i] = e[i] + 1;
        if (e[i] % 8 == 0) begin
          if ((e[i] / 8 >= syncCount[i]) && ((i == 0) ? validA : validB))
            cur[i] = (i == 0) ? dataA : dataB;
          else
            cur[i] = COM;
        end
        expDo[i]   = cur[i][7 - (e[i] % 8)];
        expSync[i] = (e[i] < 8 * (syncCount[i] - 1));
      end
    end
  end

  // Compare both transmitters against the model in the middle of every cycle.
  always @(negedge CLK) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        logic expRdy;
        expRdy = !RESET && ((e[i] + 1) % 8 == 0) && (e[i] + 1 >= 8 * syncCount[i]);
        checkOutput((i == 0) ? "A.DATA_OUT" : "B.DATA_OUT", {7'd0, (i == 0) ? doutA : doutB}, {7'd0, expDo[i]});
        checkOutput((i == 0) ? "A.TX_SYNC" : "B.TX_SYNC", {7'd0, (i == 0) ? syncA : syncB}, {7'd0, expSync[i]});
        checkOutput((i == 0) ? "A.READY" : "B.READY", {7'd0, (i == 0) ? readyA : readyB}, {7'd0, expRdy});
      end
    end
  end

  // Far-end receiver on link B: locks on the first comma, then collects bytes.
  logic [7:0] rxsh;
  bit         locked;
  int         rxBits;
  logic [7:0] rxq[$];

  always @(negedge CLK) begin
    if (RESET) begin
      rxsh   = 8'd0;
      locked = 0;
      rxBits = 0;
      rxq.delete();
    end else if (live) begin
      rxsh = {rxsh[6:0], doutB};
      if (!locked) begin
        if (rxsh == COM) begin
          locked = 1;
          rxBits = 0;
        end
      end else begin
        rxBits++;
        if (rxBits == 8) begin
          rxq.push_back(rxsh);
          rxBits = 0;
        end
      end
    end
  end

  initial begin
    logic [7:0]  comma;
    logic [7:0]  a5;
    logic [23:0] btb;
    logic [7:0]  expRx [4];
    int          readyCount;
    comma = COM;
    a5    = 8'hA5;
    btb   = 24'h01FF00;
    expRx = '{8'h3C, 8'hBC, 8'h7E, 8'hBC};

    RESET = 1'b1; validA = 1'b0; dataA = 8'd0; validB = 1'b0; dataB = 8'd0;
    $display("[TB] start");

    // Reset, idle preamble, a single byte, back-to-back bytes and the B loopback.
    applyStimulus(1, 0, 8'd0, 0, 8'd0);
    applyStimulus(1, 0, 8'd0, 0, 8'd0);
    checkOutput("reset DATA_OUT", {7'd0, doutA}, 8'd0);
    checkOutput("reset TX_SYNC", {7'd0, syncA}, 8'd1);
    checkOutput("reset READY", {7'd0, readyA}, 8'd0);
    for (int j = 0; j < 48; j++) begin
      logic       va, vb;
      logic [7:0] da, db;
      va = 0; da = 8'($urandom);
      vb = 0; db = 8'($urandom);
      case (j)
        16: begin va = 1; da = 8'hA5; end
        24: begin va = 1; da = 8'h01; end
        32: begin va = 1; da = 8'hFF; end
        40: begin va = 1; da = 8'h00; end
        default: ;
      endcase
      case (j)
        8:  begin vb = 1; db = 8'h3C; end
        16: begin vb = 1; db = 8'hBC; end
        24: begin vb = 1; db = 8'h7E; end
        default: ;
      endcase
      applyStimulus(0, va, da, vb, db);
      if (j < 8)  checkOutput("idle comma bit", {7'd0, doutA}, {7'd0, comma[7 - j]});
      if (j == 7) checkOutput("TX_SYNC edge 7", {7'd0, syncA}, 8'd1);
      if (j == 8) checkOutput("TX_SYNC edge 8", {7'd0, syncA}, 8'd0);
      if (j == 14) checkOutput("READY cycle 14", {7'd0, readyA}, 8'd0);
      if (j == 15) checkOutput("READY cycle 15", {7'd0, readyA}, 8'd1);
      if (j == 0) checkOutput("B TX_SYNC edge 0", {7'd0, syncB}, 8'd0);
      if (j == 6) checkOutput("B READY cycle 6", {7'd0, readyB}, 8'd0);
      if (j == 7) checkOutput("B READY cycle 7", {7'd0, readyB}, 8'd1);
      if (j >= 16 && j < 24) checkOutput("A5 bit", {7'd0, doutA}, {7'd0, a5[23 - j]});
      if (j >= 24) checkOutput("b2b bit", {7'd0, doutA}, {7'd0, btb[47 - j]});
    end
    checkOutput("rx count", rxq.size() >= 4 ? 8'd1 : 8'd0, 8'd1);
    for (int k = 0; k < 4; k++)
      if (k < rxq.size()) checkOutput("rx byte", rxq[k], expRx[k]);

    // Reset after edge 20 while a byte is in flight, then resynchronise.
    applyStimulus(1, 0, 8'd0, 0, 8'd0);
    for (int j = 0; j < 21; j++)
      applyStimulus(0, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    applyStimulus(1, 1, 8'h5A, 1, 8'h5A);
    checkOutput("midbyte reset DATA_OUT", {7'd0, doutA}, 8'd0);
    checkOutput("midbyte reset TX_SYNC", {7'd0, syncA}, 8'd1);
    for (int j = 0; j < 16; j++) begin
      applyStimulus(0, 1, 8'($urandom), 1, 8'($urandom));
      if (j == 14) checkOutput("restart READY cycle 14", {7'd0, readyA}, 8'd0);
      if (j == 15) checkOutput("restart READY cycle 15", {7'd0, readyA}, 8'd1);
    end

    // VALID_IN held high with DATA_IN changing on every cycle: one READY per 8 cycles.
    readyCount = 0;
    for (int j = 0; j < 80; j++) begin
      applyStimulus(0, 1, 8'($urandom), 1, 8'($urandom));
      if (readyA) readyCount++;
    end
    checkOutput("READY pulses in 80 cycles", 8'(readyCount), 8'd10);

    // Random traffic with occasional resets.
    for (int j = 0; j < 600; j++)
      applyStimulus(($urandom_range(0, 149) == 0), 1'($urandom), 8'($urandom),
                    1'($urandom), 8'($urandom));

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_serial_tx.md
# parallel_serial_tx

Byte-to-serial transmitter feeding the single-bit comma-framed link. After reset it sends a configurable number of comma bytes (0xBC) so the far-end deserializer can lock its byte alignment. It then serializes one byte every 8 clocks, MSB first, with no gaps. Bytes come from an upstream source over a READY/VALID handshake, and idle slots are filled with the comma byte.

## Interface

- COM, 8'hBC, comma/idle byte, sent during sync and in every unfilled slot
- SYNC_COUNT, 2, number of comma bytes sent after reset before data is accepted; legal range 1..255
- CLK  input  1  single clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- DATA_IN  input  8  parallel byte to transmit; sampled only on a load edge with READY=1
- VALID_IN  input  1  DATA_IN holds a byte to send
- READY  output  1  high during the cycle before a data-phase load edge
- DATA_OUT  output  1  registered serial bit, MSB first
- TX_SYNC  output  1  high while in SYNC state (comma preamble)

## Operation

- State: 2-state FSM {SYNC, DATA}; 3-bit bit counter `cnt`; 8-bit shift register `sh`; sync counter of width clog2(SYNC_COUNT+1).
- Reset (RESET=1 at an edge), applied regardless of state or `cnt`:
  - state=SYNC, cnt=0, sync counter=0, sh=0, DATA_OUT=0.
  - TX_SYNC=1.
  - READY=0, because READY is gated by !RESET.
- Every non-reset edge increments cnt (mod 8, wraps 7->0).
- Load edge: a non-reset edge with cnt==0. It loads the selected byte B into sh and drives DATA_OUT<=B[7].
- Non-load edge: sh shifts left one bit and DATA_OUT<=next bit. After the 7 following edges DATA_OUT shows B[6]..B[0].
- SYNC state:
  - Every load edge loads COM and increments the sync counter.
  - The load edge that loads the SYNC_COUNT-th comma moves state to DATA.
  - VALID_IN and DATA_IN are ignored and READY=0.
- DATA state:
  - READY = (cnt==0) && !RESET, which is combinational from registered state.
  - On a load edge, VALID_IN=1 loads DATA_IN (byte accepted, consumed by the source). VALID_IN=0 loads COM (idle).
  - VALID_IN or DATA_IN changes while READY=0 have no effect.
- The DATA state persists until RESET; there is no other path back to SYNC.
- The comma value is not escaped: a data byte equal to COM is sent verbatim.

## Timing

- Edge 0 is the first rising edge with RESET=0. Load edges are 0, 8, 16, ….
- TX_SYNC falls after edge 8·(SYNC_COUNT−1). With the default this is after edge 8.
- READY is first high in the cycle between edges 8·SYNC_COUNT−1 and 8·SYNC_COUNT. With the default this is between edges 15 and 16.
- Handshake latency:
  - A byte accepted at load edge k has its MSB on DATA_OUT after edge k and its LSB after edge k+7.
  - The next byte's MSB follows after edge k+8, with no bubble.
- Throughput is 1 byte / 8 clocks. READY is high exactly 1 cycle in 8.
- RESET mid-byte:
  - The partial byte is abandoned and DATA_OUT=0 after the reset edge.
  - A byte accepted at the same edge as RESET=1 is discarded. Reset has priority, and READY is already 0 in that cycle.
- DATA_OUT never goes X after the first reset edge.

## Test plan

- **Reset then idle, default parameters, VALID_IN=0:**
  - DATA_OUT after edges 0..7 = 1,0,1,1,1,1,0,0, repeating every 8 edges indefinitely.
  - TX_SYNC=1 through edge 8 and 0 after it.
  - READY pulses in cycles 15, 23, 31, ….
- **Single byte 0xA5 with VALID_IN=1 at the first READY:**
  - DATA_OUT after edges 16..23 = 1,0,1,0,0,1,0,1.
  - Edges 24..31 then carry 0xBC.
- **Back-to-back bytes 0x01, 0xFF, 0x00, each on consecutive READY cycles:**
  - DATA_OUT after edges 16..39 = 00000001 11111111 00000000, with no gap.
- **VALID_IN held high with DATA_IN changing every cycle:** only the values present in READY cycles are transmitted, i.e. exactly one byte per 8 edges.
- **RESET asserted after edge 20 (mid-byte), deasserted one cycle later:**
  - DATA_OUT=0 after the reset edge.
  - The sequence restarts with 2 commas from the new edge 0.
  - READY stays 0 until the new cycle 15.
- **SYNC_COUNT=1 and loopback into the receiving deserializer with bytes 0x3C, 0xBC, 0x7E:**
  - TX_SYNC falls after edge 0.
  - READY is first high in cycle 7.
  - The receiver locks on the comma, then outputs 0x3C, 0xBC, 0x7E in order, followed by idle 0xBC.
